// File: rtl/mips32_loader_pkg.sv
// mips32_loader_pkg: shared state encoding, error codes and frame constants for the program loader
package mips32_loader_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD, CSUM, START, RUN, ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mips32_byte_packer.sv
// mips32_byte_packer: assembles 4 bytes MSB first; word_valid flags the byte completing a word
module mips32_byte_packer
  import mips32_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [23:0] r_sh;
  logic [1:0]  r_idx;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sh  <= '0;
      r_idx <= '0;
    end else if (i_en) begin
      r_sh  <= {r_sh[15:0], i_byte};
      r_idx <= r_idx + 2'd1;
    end
  end
  // the completing byte is merged combinationally so the write lands one cycle after it
  assign o_word       = {r_sh, i_byte};
  assign o_word_valid = i_en && (r_idx == 2'(WORD_BYTES - 1));
endmodule

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: byte-stream frame loader that fills core memory then releases the core.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              done,
  output logic [1:0]        err_code
);
  localparam int DEPTH = 2 ** ADDR_W;
  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be positive");
  end
  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_wcnt;
  logic [7:0]  r_csum;
  logic [1:0]  r_err;
  logic        w_acc;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic        w_word_valid;
`ifdef LOADER_TIMEOUT_EN
  logic [31:0] r_tmo;
`endif
  assign w_acc     = in_valid && in_ready;
  assign w_len     = {r_len[15:8], in_data};
  assign in_ready  = r_state inside {LEN_HI, LEN_LO, WORD, CSUM};
  assign cpu_hold  = !(r_state inside {START, RUN});
  assign cpu_start = r_state == START;
  assign done      = r_state == RUN;
  assign err_code  = r_err;
  mips32_byte_packer u_packer (
    .clk         (clk1),
    .rst         (rst),
    .i_clr       (r_state != WORD),
    .i_en        (w_acc && r_state == WORD),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state   <= LEN_HI;
      r_len     <= '0;
      r_wcnt    <= '0;
      r_csum    <= '0;
      r_err     <= ERR_NONE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef LOADER_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        LEN_HI: if (w_acc) begin
          r_len[15:8] <= in_data;
          r_csum      <= r_csum ^ in_data;
          r_state     <= LEN_LO;
        end
        LEN_LO: if (w_acc) begin
          r_len   <= w_len;
          r_csum  <= r_csum ^ in_data;
          r_state <= (w_len == 16'd0) ? CSUM :
                     ({1'b0, w_len} > 17'(DEPTH - BASE_ADDR)) ? ERR : WORD;
          if (w_len != 16'd0 && {1'b0, w_len} > 17'(DEPTH - BASE_ADDR)) r_err <= ERR_LEN;
        end
        WORD: if (w_acc) begin
          r_csum <= r_csum ^ in_data;
          if (w_word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(BASE_ADDR) + r_wcnt[ADDR_W-1:0];
            mem_wdata <= w_word;
            r_wcnt    <= r_wcnt + 16'd1;
            if (r_wcnt + 16'd1 == r_len) r_state <= CSUM;
          end
        end
        CSUM: if (w_acc) begin
          r_state <= (in_data == r_csum) ? START : ERR;
          if (in_data != r_csum) r_err <= ERR_CSUM;
        end
        START: r_state <= RUN;
        default: r_state <= r_state;
      endcase
`ifdef LOADER_TIMEOUT_EN
      // only mid-frame stalls count; idling before a frame never times out
      if (w_acc || !(r_state inside {LEN_LO, WORD, CSUM})) r_tmo <= '0;
      else if (r_tmo == 32'(TIMEOUT_CYC - 1)) begin
        r_state <= ERR;
        r_err   <= ERR_TMO;
      end else r_tmo <= r_tmo + 32'd1;
`endif
    end
  end
endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: randomized frames checked each cycle against a byte-position reference model
module tb_mips32_prog_loader;
  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_hold, cpu_start, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  int checks = 0, failures = 0;
  int cyc = 0;
  mips32_prog_loader dut (
    .clk1(clk1), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .cpu_start(cpu_start), .done(done), .err_code(err_code)
  );
  always #5 clk1 = ~clk1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // reference model: status 0 loading, 1 start pulse, 2 running, 3 error
  bit          m_init = 0;
  int          m_st, m_pos, m_len;
  logic [7:0]  m_x;
  logic [1:0]  m_err;
  logic [31:0] m_word, m_wdata;
  int          m_addr;
  bit          m_we;
  always @(posedge clk1) begin
    cyc++;
    if (rst) begin
      m_init = 1; m_st = 0; m_pos = 0; m_len = 0; m_x = 0; m_err = 0; m_we = 0; m_word = 0;
    end else begin
      m_we = 0;
      if (m_st == 1) m_st = 2;
      else if (m_st == 0 && in_valid) begin
        int p;
        p = m_pos;
        m_pos++;
        if (p == 0) begin m_len = int'(in_data) << 8; m_x ^= in_data; end
        else if (p == 1) begin
          m_len += int'(in_data); m_x ^= in_data;
          if (m_len > 1024) begin m_st = 3; m_err = 1; end
        end else if (p < 2 + 4 * m_len) begin
          m_x ^= in_data;
          m_word = {m_word[23:0], in_data};
          if ((p - 2) % 4 == 3) begin m_we = 1; m_addr = (p - 2) / 4; m_wdata = m_word; end
        end else if (in_data == m_x) m_st = 1;
        else begin m_st = 3; m_err = 2; end
      end
    end
  end
  logic [31:0] wr_log [0:1023];
  int wr_cnt = 0;
  always @(negedge clk1) if (m_init) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_st == 0});
    chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    if (m_we) begin
      chk("mem_addr", {22'd0, mem_addr}, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("cpu_start", {31'd0, cpu_start}, {31'd0, m_st == 1});
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_st == 0 || m_st == 3});
    chk("done", {31'd0, done}, {31'd0, m_st == 2});
    chk("err_code", {30'd0, err_code}, {30'd0, m_err});
    if (mem_we) begin wr_log[mem_addr] = mem_wdata; wr_cnt++; end
  end
  logic [7:0]  fq[$];
  logic [7:0]  fx;
  logic [31:0] wbuf [0:1023];
  task automatic pb(input logic [7:0] b);
    fq.push_back(b);
    fx ^= b;
  endtask
  task automatic mk_frame(input int n, input bit bad);
    fq.delete();
    fx = 0;
    pb(8'(n >> 8)); pb(8'(n));
    for (int i = 0; i < n; i++) for (int k = 3; k >= 0; k--) pb(8'(wbuf[i] >> (8 * k)));
    fq.push_back(fx ^ {7'd0, bad});
  endtask
  // mode 0 always valid, 1 valid every other cycle, 2 random valid
  task automatic send(input int mode, input int nbytes);
    int lim;
    lim = (nbytes < 0) ? fq.size() : nbytes;
    for (int i = 0; i < lim; i++) begin
      bit acc;
      int tries;
      acc = 0; tries = 0;
      while (!acc) begin
        @(negedge clk1);
        in_data  = fq[i];
        in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        #1;
        acc = in_valid && in_ready;
        if (++tries > 100) begin
          failures++;
          $display("FAIL send_stall actual=byte%0d_not_accepted required=accepted", i);
          @(negedge clk1); in_valid = 0;
          return;
        end
      end
    end
    @(negedge clk1); in_valid = 0;
  endtask
  task automatic do_rst();
    @(negedge clk1); rst = 1; in_valid = 0;
    @(negedge clk1); @(negedge clk1); rst = 0;
    wr_cnt = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk1);
  endtask
  initial begin
    do_rst();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done_err", {29'd0, done, err_code}, 32'd0);
    wbuf[0] = 32'h2801000A;
    mk_frame(1, 0);
    chk("frame_a_csum", {24'd0, fq[6]}, 32'h22);
    send(0, -1); idle(3);
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_err", {30'd0, err_code}, 32'd0);
    chk("a_wr_cnt", wr_cnt, 32'd1);
    chk("a_word0", wr_log[0], 32'h2801000A);
    in_valid = 1; idle(4); in_valid = 0;
    chk("a_run_ignores_bytes", {31'd0, done}, 32'd1);
    do_rst();
    mk_frame(1, 1);
    chk("frame_b_csum", {24'd0, fq[6]}, 32'h23);
    send(0, -1); idle(3);
    chk("b_err", {30'd0, err_code}, 32'd2);
    chk("b_hold_ready", {30'd0, cpu_hold, in_ready}, 32'b10);
    chk("b_wr_cnt", wr_cnt, 32'd1);
    do_rst();
    mk_frame(0, 0);
    send(0, -1); idle(3);
    chk("c_done", {31'd0, done}, 32'd1);
    chk("c_wr_cnt", wr_cnt, 32'd0);
    do_rst();
    fq.delete(); fq.push_back(8'h04); fq.push_back(8'h01);
    send(0, -1); idle(2);
    chk("d_err", {30'd0, err_code}, 32'd1);
    chk("d_ready_we", {30'd0, in_ready, mem_we}, 32'd0);
    chk("d_wr_cnt", wr_cnt, 32'd0);
    do_rst();
    wbuf[0] = 32'h2801000A; wbuf[1] = 32'h28020014; wbuf[2] = 32'h28030019;
    wbuf[3] = 32'h0CE77800; wbuf[4] = 32'h0CE77800; wbuf[5] = 32'h00222000;
    wbuf[6] = 32'h0CE77800; wbuf[7] = 32'h00832800; wbuf[8] = 32'hFC000000;
    mk_frame(9, 0);
    send(1, -1); idle(3);
    chk("e_done", {31'd0, done}, 32'd1);
    chk("e_wr_cnt", wr_cnt, 32'd9);
    chk("e_word5", wr_log[5], 32'h00222000);
    chk("e_word8", wr_log[8], 32'hFC000000);
    do_rst();
    send(0, 5);
    do_rst();
    chk("f_partial_no_write", wr_cnt, 32'd0);
    send(2, -1); idle(3);
    chk("f_done", {31'd0, done}, 32'd1);
    chk("f_wr_cnt", wr_cnt, 32'd9);
    do_rst();
    for (int i = 0; i < 1024; i++) wbuf[i] = $urandom;
    mk_frame(1024, 0);
    send(0, -1); idle(3);
    chk("g_full_done", {31'd0, done}, 32'd1);
    chk("g_full_wr_cnt", wr_cnt, 32'd1024);
    chk("g_last_word", wr_log[1023], wbuf[1023]);
    for (int r = 0; r < 8; r++) begin
      int n;
      bit bad;
      do_rst();
      n = $urandom_range(1, 6);
      bad = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      mk_frame(n, bad);
      send(2, -1); idle(3);
      chk("r_err", {30'd0, err_code}, bad ? 32'd2 : 32'd0);
      chk("r_wr_cnt", wr_cnt, n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Byte-stream program loader that writes the pipe_MIPS32 instruction/data memory and then releases the core. It replaces bench-side hierarchical preloading of memory, PC, HALTED and TAKEN_BRANCH.
- Sits between a host byte link (valid/ready) and the core's memory write port plus its start/hold controls.
- Frame format, all multi-byte fields MSB first:
  - LEN: 2 bytes, word count.
  - WORDS: LEN × 4 bytes.
  - CSUM: 1 byte, the XOR of every preceding byte in the frame.

Parameters:
- ADDR_W, 10, memory word-address width; DEPTH = 2**ADDR_W (1024 words).
- BASE_ADDR, 0, word address receiving the first loaded word.
- TIMEOUT_CYC, 1000, inter-byte timeout in clk1 cycles; used only with LOADER_TIMEOUT_EN.

Ports:
- clk1  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a clk1 edge.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  core held halted (HALTED forced 1).
- cpu_start  out  1  one-cycle pulse; the core clears PC, HALTED and TAKEN_BRANCH on it.
- done  out  1  load complete, core running.
- err_code  out  2  0 none, 1 length overflow, 2 checksum, 3 timeout.

Behaviour:
- Interface: one clock (clk1); reset is synchronous and active-high (rst).
- Reset values: state=LEN_HI, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, done=0, err_code=0; internal csum, len, word count and byte index all 0.
- in_ready is a Moore output of state: 1 in LEN_HI, LEN_LO, WORD and CSUM; 0 elsewhere.
- FSM states and transitions:
  - LEN_HI: on accept, len[15:8]=byte, go to LEN_LO.
  - LEN_LO: on accept, len[7:0]=byte.
    - If len==0, go to CSUM.
    - Else if len>DEPTH-BASE_ADDR, go to ERR with err_code=1. This is evaluated in the same cycle, before the checksum is seen.
    - Else go to WORD.
  - WORD: bytes shift into a 32-bit assembler MSB first; byte index counts 0..3.
    - On the 4th accepted byte, the next cycle drives mem_we=1, mem_addr=BASE_ADDR+wcnt, mem_wdata=assembled word. Latency is 1 cycle from the 4th byte.
    - wcnt then increments. When wcnt reaches len, go to CSUM.
  - CSUM: on accept, compare the byte with the running XOR.
    - Match: go to START.
    - Mismatch: go to ERR with err_code=2.
  - START: one cycle with cpu_start=1 and cpu_hold=0, then go to RUN.
  - RUN: done=1, cpu_hold=0; held until rst.
  - ERR: cpu_hold=1, err_code sticky; held until rst. No cpu_start is issued.
- Running XOR covers both LEN bytes and all WORD bytes.
- mem_addr arithmetic is modulo 2**ADDR_W; the length check guarantees no wrap.
- mem_we is never asserted outside WORD-completion cycles. mem_addr and mem_wdata hold their last values when mem_we=0.
- Back-pressure: in_valid low simply stalls the FSM; there is no state change and no byte loss.
- rst mid-frame aborts the load: partial words are discarded, already-written words are not undone, and the FSM returns to LEN_HI with cpu_hold=1.
- rst takes priority over any simultaneous byte transfer.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - A counter resets on every accepted byte. It runs only in LEN_LO, WORD and CSUM, i.e. mid-frame, not while idling in LEN_HI.
  - When it reaches TIMEOUT_CYC, go to ERR with err_code=3.
- Undefined: no counter; a mid-frame stall may last indefinitely, and err_code never takes value 3.

Decomposition:
- Package mips32_loader_pkg holds:
  - State encoding: LEN_HI, LEN_LO, WORD, CSUM, START, RUN, ERR.
  - err_code constants: ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TMO.
  - Frame constants: LEN_BYTES=2, WORD_BYTES=4.
- One sub-module, mips32_byte_packer: shift/assemble 4 bytes MSB first, with a word_valid pulse and clear input.

Test Plan:
- Frame 00 01 28 01 00 0A 22 → single mem_we at addr 0, wdata 32'h2801000A; cpu_start one-cycle pulse one cycle after the CSUM byte; done=1; err_code=0.
- Same frame with CSUM 23 → mem_we once (addr 0), no cpu_start, cpu_hold=1, err_code=2, in_ready=0.
- Frame 00 00 00 → no mem_we; START then RUN immediately after CSUM.
- ADDR_W=10, LEN bytes 04 01 → err_code=1 the cycle after the 2nd byte, in_ready=0, no mem_we.
- 9-word program (ADDI×3, NOP×2, ADD, NOP, ADD, HALT) sent with in_valid toggling every other cycle → addresses 0..8 written in order with the exact words; CSUM matches; done=1.
- rst asserted after 3 bytes of word 0, then full frame resent → no write from the partial word; normal completion. With LOADER_TIMEOUT_EN and TIMEOUT_CYC=16, stall 16 cycles in WORD → err_code=3.
